// File: rtl/atomrvcore_fetch_queue.sv
// rtl/atomrvcore_fetch_queue.sv - instruction prefetch queue with redirect flush
// Optional event counters enabled by defining ATOM_FQ_STATS_EN.
module atomrvcore_fetch_queue #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                 clk_i,
    input  logic                 PCrst_i,
    input  logic                 redirect_i,
    input  logic [DATAWIDTH-1:0] pc_i,
    output logic                 imem_req_o,
    output logic [DATAWIDTH-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [DATAWIDTH-1:0] imem_rdata_i,
    output logic                 instr_valid_o,
    output logic [DATAWIDTH-1:0] instr_o,
    output logic [DATAWIDTH-1:0] instr_pc_o,
    input  logic                 instr_ready_i
`ifdef ATOM_FQ_STATS_EN
    ,
    output logic [31:0]          flush_cnt_o,
    output logic [31:0]          stall_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FLUSH
    } state_t;

    state_t               r_state;
    logic [DATAWIDTH-1:0] r_fetch_pc;
    logic [DATAWIDTH-1:0] r_req_pc;
    logic [DATAWIDTH-1:0] r_instr_mem [DEPTH];
    logic [DATAWIDTH-1:0] r_pc_mem    [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;

    logic                 w_in_wait;
    logic [AW+1:0]        w_used;
    logic                 w_credit_ok;
    logic                 w_valid;
    logic                 w_push;
    logic                 w_pop;
    logic [DATAWIDTH-1:0] w_target;

    // The in-flight request reserves a slot so a response can never overflow the FIFO.
    assign w_in_wait   = (r_state == S_WAIT);
    assign w_used      = {1'b0, r_count} + (AW+2)'(w_in_wait);
    assign w_credit_ok = (w_used < (AW+2)'(DEPTH));
    assign w_valid     = (r_count != '0);
    assign w_push      = w_in_wait && imem_rvalid_i && !redirect_i;
    assign w_pop       = w_valid && instr_ready_i && !redirect_i;
    assign w_target    = pc_i & ~DATAWIDTH'(3);

    assign imem_req_o    = (r_state == S_REQ);
    assign imem_addr_o   = r_fetch_pc;
    assign instr_valid_o = w_valid;
    assign instr_o       = r_instr_mem[r_rd_ptr];
    assign instr_pc_o    = r_pc_mem[r_rd_ptr];

    always_ff @(posedge clk_i or negedge PCrst_i) begin
        if (!PCrst_i) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= '0;
            r_req_pc   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr_mem[i] <= '0;
                r_pc_mem[i]    <= '0;
            end
        end else if (redirect_i) begin
            r_fetch_pc <= w_target;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            // A granted-but-unanswered request must have its response swallowed in FLUSH.
            case (r_state)
                S_REQ:           r_state <= imem_gnt_i ? S_FLUSH : S_REQ;
                S_WAIT, S_FLUSH: r_state <= imem_rvalid_i ? S_REQ : S_FLUSH;
                default:         r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_credit_ok) r_state <= S_REQ;
                end
                S_REQ: begin
                    if (imem_gnt_i) begin
                        r_state    <= S_WAIT;
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + DATAWIDTH'(4);
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) r_state <= w_credit_ok ? S_REQ : S_IDLE;
                end
                default: begin
                    if (imem_rvalid_i) r_state <= S_REQ;
                end
            endcase

            if (w_push) begin
                r_instr_mem[r_wr_ptr] <= imem_rdata_i;
                r_pc_mem[r_wr_ptr]    <= r_req_pc;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ATOM_FQ_STATS_EN
    logic [31:0] r_flush_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge PCrst_i) begin
        if (!PCrst_i) begin
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (redirect_i && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
            if (!w_valid && instr_ready_i && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign flush_cnt_o = r_flush_cnt;
    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_atomrvcore_fetch_queue.sv
// tb/tb_atomrvcore_fetch_queue.sv - directed vector bench for atomrvcore_fetch_queue
module tb_atomrvcore_fetch_queue;

    logic        clk_i = 1'b0;
    logic        PCrst_i;
    logic        redirect_i;
    logic [31:0] pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    atomrvcore_fetch_queue #(.DATAWIDTH(32), .DEPTH(4)) dut (
        .clk_i         (clk_i),
        .PCrst_i       (PCrst_i),
        .redirect_i    (redirect_i),
        .pc_i          (pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        redirect;
        logic [31:0] pc;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t        vecs [21];
    int          n_vec = 0;
    int          n_err = 0;

    logic        pend;
    logic [31:0] pend_addr;
    int          rdy_mode;
    logic [31:0] grant_q [$];
    logic [31:0] pop_pc_q [$];
    logic [31:0] pop_ins_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic rd, input logic [31:0] pc, input logic g,
                           input logic rv, input logic [31:0] rdat, input logic rdy,
                           input logic ereq, input logic [31:0] eaddr, input logic ev,
                           input logic [31:0] epc, input logic [31:0] eins);
        vecs[i] = '{rd, pc, g, rv, rdat, rdy, ereq, eaddr, ev, epc, eins};
    endtask

    task automatic zero_inputs();
        redirect_i    = 1'b0;
        pc_i          = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        PCrst_i = 1'b0;
        zero_inputs();
        pend = 1'b0;
        pend_addr = '0;
        grant_q.delete();
        pop_pc_q.delete();
        pop_ins_q.delete();
        repeat (2) @(negedge clk_i);
        PCrst_i = 1'b1;
    endtask

    // Memory model: grant every request, answer one cycle later with rdata = ~addr.
    task automatic mem_cycle();
        @(negedge clk_i);
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if (pend) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = ~pend_addr;
            pend = 1'b0;
        end else if (imem_req_o) begin
            imem_gnt_i = 1'b1;
            pend       = 1'b1;
            pend_addr  = imem_addr_o;
            grant_q.push_back(imem_addr_o);
        end
        case (rdy_mode)
            0:       instr_ready_i = 1'b0;
            1:       instr_ready_i = 1'b1;
            default: instr_ready_i = 1'($urandom_range(0, 1));
        endcase
        if (instr_valid_o && instr_ready_i) begin
            pop_pc_q.push_back(instr_pc_o);
            pop_ins_q.push_back(instr_o);
        end
    endtask

    initial begin
        int found;
        int npop;

        //          rd  pc            g  rv rdata         rdy req addr          v  pc            instr
        set_vec( 0, 0, 32'h0,         1, 0, 32'h0,        1,  1, 32'h0,         0, 32'h0,        32'h0);
        set_vec( 1, 0, 32'h0,         0, 1, 32'h00000013, 1,  0, 32'h4,         0, 32'h0,        32'h0);
        set_vec( 2, 0, 32'h0,         1, 0, 32'h0,        1,  1, 32'h4,         1, 32'h0,        32'h00000013);
        set_vec( 3, 0, 32'h0,         0, 1, 32'h00400093, 1,  0, 32'h8,         0, 32'h0,        32'h0);
        set_vec( 4, 0, 32'h0,         1, 0, 32'h0,        1,  1, 32'h8,         1, 32'h4,        32'h00400093);
        set_vec( 5, 0, 32'h0,         0, 1, 32'h00800113, 1,  0, 32'hC,         0, 32'h0,        32'h0);
        set_vec( 6, 1, 32'h203,       0, 0, 32'h0,        1,  1, 32'hC,         1, 32'h8,        32'h00800113);
        set_vec( 7, 0, 32'h0,         1, 0, 32'h0,        1,  1, 32'h200,       0, 32'h0,        32'h0);
        set_vec( 8, 1, 32'h100,       0, 0, 32'h0,        1,  0, 32'h204,       0, 32'h0,        32'h0);
        set_vec( 9, 0, 32'h0,         0, 1, 32'hDEADBEEF, 1,  0, 32'h100,       0, 32'h0,        32'h0);
        set_vec(10, 0, 32'h0,         1, 0, 32'h0,        1,  1, 32'h100,       0, 32'h0,        32'h0);
        set_vec(11, 0, 32'h0,         0, 1, 32'h11110001, 0,  0, 32'h104,       0, 32'h0,        32'h0);
        set_vec(12, 1, 32'hFFFFFFFC,  1, 0, 32'h0,        1,  1, 32'h104,       1, 32'h100,      32'h11110001);
        set_vec(13, 0, 32'h0,         0, 1, 32'hBAD00001, 1,  0, 32'hFFFFFFFC,  0, 32'h0,        32'h0);
        set_vec(14, 0, 32'h0,         1, 0, 32'h0,        1,  1, 32'hFFFFFFFC,  0, 32'h0,        32'h0);
        set_vec(15, 0, 32'h0,         0, 1, 32'h22220002, 1,  0, 32'h0,         0, 32'h0,        32'h0);
        set_vec(16, 0, 32'h0,         0, 0, 32'h0,        1,  1, 32'h0,         1, 32'hFFFFFFFC, 32'h22220002);
        set_vec(17, 0, 32'h0,         1, 0, 32'h0,        1,  1, 32'h0,         0, 32'h0,        32'h0);
        set_vec(18, 1, 32'h40,        0, 1, 32'hBAD00002, 1,  0, 32'h4,         0, 32'h0,        32'h0);
        set_vec(19, 0, 32'h0,         0, 0, 32'h0,        1,  1, 32'h40,        0, 32'h0,        32'h0);
        set_vec(20, 0, 32'h0,         0, 0, 32'h0,        0,  1, 32'h40,        0, 32'h0,        32'h0);

        PCrst_i = 1'b0;
        zero_inputs();
        pend = 1'b0;
        pend_addr = '0;
        rdy_mode = 0;
        repeat (2) @(negedge clk_i);
        check("reset req",   32'(imem_req_o),    32'h0);
        check("reset addr",  imem_addr_o,        32'h0);
        check("reset valid", 32'(instr_valid_o), 32'h0);
        check("reset instr", instr_o,            32'h0);
        check("reset pc",    instr_pc_o,         32'h0);
        PCrst_i = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk_i);
            check($sformatf("v%0d req", i),   32'(imem_req_o),    32'(vecs[i].exp_req));
            check($sformatf("v%0d addr", i),  imem_addr_o,        vecs[i].exp_addr);
            check($sformatf("v%0d valid", i), 32'(instr_valid_o), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d ipc", i),   instr_pc_o, vecs[i].exp_pc);
                check($sformatf("v%0d instr", i), instr_o,    vecs[i].exp_instr);
            end
            redirect_i    = vecs[i].redirect;
            pc_i          = vecs[i].pc;
            imem_gnt_i    = vecs[i].gnt;
            imem_rvalid_i = vecs[i].rvalid;
            imem_rdata_i  = vecs[i].rdata;
            instr_ready_i = vecs[i].ready;
        end

        // Decoder stalled: exactly four words fetched, then requests stop.
        do_reset();
        rdy_mode = 0;
        repeat (30) mem_cycle();
        check("fill grants", grant_q.size(), 32'd4);
        for (int i = 0; i < grant_q.size() && i < 4; i++)
            check($sformatf("fill addr%0d", i), grant_q[i], 32'(4 * i));
        check("fill req idle", 32'(imem_req_o),    32'h0);
        check("fill valid",    32'(instr_valid_o), 32'h1);
        check("fill head pc",  instr_pc_o,         32'h0);

        // Random back-pressure from full, then drain: order and data must survive.
        rdy_mode = 2;
        repeat (200) mem_cycle();
        rdy_mode = 1;
        repeat (20) mem_cycle();
        npop = pop_pc_q.size();
        check("stream pops", 32'(npop >= 40), 32'h1);
        check("stream in flight", 32'(grant_q.size() - npop <= 5), 32'h1);
        for (int i = 0; i < npop; i++) begin
            check($sformatf("stream pc%0d", i),    pop_pc_q[i],  32'(4 * i));
            check($sformatf("stream instr%0d", i), pop_ins_q[i], ~(32'(4 * i)));
        end

        // Asynchronous reset while a request is outstanding with data buffered.
        rdy_mode = 0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            mem_cycle();
            if (pend && instr_valid_o) found = 1;
        end
        check("areset setup", 32'(found), 32'h1);
        @(posedge clk_i);
        #2;
        PCrst_i = 1'b0;
        #1;
        check("areset req",   32'(imem_req_o),    32'h0);
        check("areset addr",  imem_addr_o,        32'h0);
        check("areset valid", 32'(instr_valid_o), 32'h0);
        check("areset instr", instr_o,            32'h0);
        check("areset pc",    instr_pc_o,         32'h0);
        do_reset();
        rdy_mode = 1;
        repeat (12) mem_cycle();
        check("restart grants", 32'(grant_q.size() > 0), 32'h1);
        if (grant_q.size() > 0) check("restart addr", grant_q[0], 32'h0);
        check("restart pops", 32'(pop_pc_q.size() > 0), 32'h1);
        if (pop_pc_q.size() > 0) check("restart pc", pop_pc_q[0], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
